sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_if.sv | 41 ++++
 rtl/sdram_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter_if.sv
// Bundle of requester-side and controller-side signals for the two-port SDRAM arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view
// (requesters plus the SDRAM controller).
interface sdram_arbiter_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [23:0] req0_addr;
  logic [23:0] req1_addr;
  logic        req0_write;
  logic        req1_write;
  logic [31:0] req0_wdata;
  logic [31:0] req1_wdata;
  logic        req0_ack;
  logic        req1_ack;
  logic [31:0] rdata;
  logic [1:0]  grant;
  logic        busy;
  logic        err;
  logic        mem_enable;
  logic [23:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  req0_valid, req1_valid, req0_addr, req1_addr,
    input  req0_write, req1_write, req0_wdata, req1_wdata,
    input  mem_rdata, mem_ready,
    output req0_ack, req1_ack, rdata, grant, busy, err,
    output mem_enable, mem_addr, mem_write, mem_wdata
  );

  modport master (
    output req0_valid, req1_valid, req0_addr, req1_addr,
    output req0_write, req1_write, req0_wdata, req1_wdata,
    output mem_rdata, mem_ready,
    input  req0_ack, req1_ack, rdata, grant, busy, err,
    input  mem_enable, mem_addr, mem_write, mem_wdata
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of a single-command SDRAM controller.
// One access is in flight at a time: IDLE -> ISSUE -> WAIT_DONE -> ACK -> IDLE.
// A watchdog counter aborts an access that spends TIMEOUT cycles in ISSUE/WAIT_DONE
// and raises a sticky err flag.
// Build option: define SDRAM_ARB_RR_EN for round-robin between the ports;
// without it, port 0 has fixed priority.
module sdram_arbiter #(
  parameter int TIMEOUT = 63
) (
  input logic           clk,
  input logic           rst,
  sdram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, ACK} state_t;

  // Counter value seen in the last cycle that is still allowed before the abort.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic        mem_enable_q, mem_enable_n;
  logic [23:0] mem_addr_q, mem_addr_n;
  logic        mem_write_q, mem_write_n;
  logic [31:0] mem_wdata_q, mem_wdata_n;
  logic [1:0]  grant_q, grant_n;
  logic        busy_q, busy_n;
  logic        ack0_q, ack0_n;
  logic        ack1_q, ack1_n;
  logic [31:0] rdata_q, rdata_n;
  logic        err_q, err_n;
  logic [7:0]  tcount_q, tcount_n;
  logic        pick1;

`ifdef SDRAM_ARB_RR_EN
  // last_q = 1 means port 1 received the most recent grant.
  logic        last_q, last_n;

  assign pick1 = bus.req1_valid && (!bus.req0_valid || !last_q);
`else
  assign pick1 = !bus.req0_valid;
`endif

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_n     = state;
    mem_enable_n = mem_enable_q;
    mem_addr_n  = mem_addr_q;
    mem_write_n = mem_write_q;
    mem_wdata_n = mem_wdata_q;
    grant_n     = grant_q;
    ack0_n      = 1'b0;
    ack1_n      = 1'b0;
    rdata_n     = rdata_q;
    err_n       = err_q;
    tcount_n    = tcount_q;
`ifdef SDRAM_ARB_RR_EN
    last_n      = last_q;
`endif
    case (state)
      IDLE: begin
        grant_n      = 2'b00;
        mem_enable_n = 1'b0;
        if (bus.mem_ready && (bus.req0_valid || bus.req1_valid)) begin
          state_n      = ISSUE;
          mem_enable_n = 1'b1;
          tcount_n     = 8'd0;
          if (pick1) begin
            mem_addr_n  = bus.req1_addr;
            mem_write_n = bus.req1_write;
            mem_wdata_n = bus.req1_wdata;
            grant_n     = 2'b10;
`ifdef SDRAM_ARB_RR_EN
            last_n      = 1'b1;
`endif
          end else begin
            mem_addr_n  = bus.req0_addr;
            mem_write_n = bus.req0_write;
            mem_wdata_n = bus.req0_wdata;
            grant_n     = 2'b01;
`ifdef SDRAM_ARB_RR_EN
            last_n      = 1'b0;
`endif
          end
        end
      end
      ISSUE, WAIT_DONE: begin
        tcount_n = tcount_q + 8'd1;
        if (tcount_q == TIMEOUT_LAST) begin
          err_n        = 1'b1;
          mem_enable_n = 1'b0;
          ack0_n       = grant_q[0];
          ack1_n       = grant_q[1];
          state_n      = ACK;
        end else if (state == ISSUE) begin
          if (!bus.mem_ready) begin
            mem_enable_n = 1'b0;
            state_n      = WAIT_DONE;
          end
        end else if (bus.mem_ready) begin
          if (!mem_write_q) begin
            rdata_n = bus.mem_rdata;
          end
          ack0_n  = grant_q[0];
          ack1_n  = grant_q[1];
          state_n = ACK;
        end
      end
      ACK: begin
        grant_n = 2'b00;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mem_enable_q <= 1'b0;
      mem_addr_q   <= 24'd0;
      mem_write_q  <= 1'b0;
      mem_wdata_q  <= 32'd0;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      tcount_q     <= 8'd0;
`ifdef SDRAM_ARB_RR_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state        <= state_n;
      mem_enable_q <= mem_enable_n;
      mem_addr_q   <= mem_addr_n;
      mem_write_q  <= mem_write_n;
      mem_wdata_q  <= mem_wdata_n;
      grant_q      <= grant_n;
      busy_q       <= busy_n;
      ack0_q       <= ack0_n;
      ack1_q       <= ack1_n;
      rdata_q      <= rdata_n;
      err_q        <= err_n;
      tcount_q     <= tcount_n;
`ifdef SDRAM_ARB_RR_EN
      last_q       <= last_n;
`endif
    end
  end

  assign bus.mem_enable = mem_enable_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  assign bus.req0_ack   = ack0_q;
  assign bus.req1_ack   = ack1_q;
  assign bus.rdata      = rdata_q;
  assign bus.err        = err_q;

endmodule
